// File: rtl/csr_pkg.sv
// Shared types, CSR address map and the read-modify-write helper for the counter CSR file.
package csr_pkg;

  localparam int unsigned CSR_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPM_BASE      = 12'hC03;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  function automatic logic [CSR_XLEN_MAX-1:0] csr_apply_op(
    input csr_op_e                 op,
    input logic [CSR_XLEN_MAX-1:0] old_val,
    input logic [CSR_XLEN_MAX-1:0] wdata
  );
    logic [CSR_XLEN_MAX-1:0] res;
    res = old_val;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old_val | wdata;
      CSR_OP_CLEAR: res = old_val & ~wdata;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One wrapping machine counter: write beats increment, registered carry-out pulse.
module csr_counter
  import csr_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned INC_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INC_W-1:0]  inc_i,
  input  logic              inhibit_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   value_o,
  output logic              ovf_o
);

  logic [XLEN-1:0] value_q, value_d;
  logic            ovf_q, ovf_d;
  logic [XLEN:0]   sum;

  always_comb begin
    sum     = {1'b0, value_q} + (XLEN+1)'(inc_i);
    value_d = value_q;
    ovf_d   = 1'b0;
    if (we_i) begin
      value_d = wdata_i;
    end else if (!inhibit_i) begin
      value_d = sum[XLEN-1:0];
      ovf_d   = sum[XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/csr_counter_file.sv
// Scratch CSRs, machine/user counters and mcountinhibit behind a single-cycle access port.
module csr_counter_file
  import csr_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NUM_HPM       = 4,
  parameter int unsigned SCRATCH_DEPTH = 32,
  parameter int unsigned RETIRE_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  input  logic [1:0]           req_op_i,
  input  logic [11:0]          req_addr_i,
  input  logic [XLEN-1:0]      req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [XLEN-1:0]      rsp_rdata_o,
  output logic                 rsp_illegal_o,
  input  logic [RETIRE_W-1:0]  instret_inc_i,
  input  logic [NUM_HPM-1:0]   hpm_event_i,
  output logic [NUM_HPM+1:0]   ovf_o
);

  localparam int unsigned NCNT   = NUM_HPM + 2;
  localparam int unsigned CIDX_W = $clog2(NCNT);
  localparam int unsigned SIDX_W = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;

  logic [XLEN-1:0]     scratch_q [SCRATCH_DEPTH];
  logic [NCNT-1:0]     inh_q, inh_d;
  logic [XLEN-1:0]     inh_rd;

  logic [XLEN-1:0]     ctr_value [NCNT];
  logic [RETIRE_W-1:0] ctr_inc   [NCNT];
  logic [NCNT-1:0]     ctr_ovf;
  logic [NCNT-1:0]     ctr_we;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_illegal_q, rsp_illegal_d;
  logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;

  csr_op_e             op;
  logic                hit_scr, hit_mctr, hit_uctr, hit_inh, illegal, wr;
  logic [7:0]          ctr_num;
  logic [CIDX_W-1:0]   cidx;
  logic [SIDX_W-1:0]   sidx;
  logic [XLEN-1:0]     old_val, new_val;

  // Counter k lives at mcountinhibit bit 0 (k=0) or bit k+1 (minstret and hpm).
  always_comb begin
    inh_rd    = '0;
    inh_rd[0] = inh_q[0];
    inh_rd[2] = inh_q[1];
    for (int unsigned i = 0; i < NUM_HPM; i++) begin
      inh_rd[3+i] = inh_q[2+i];
    end
  end

  always_comb begin
    op       = csr_op_e'(req_op_i);
    hit_scr  = req_addr_i < 12'(SCRATCH_DEPTH);
    hit_mctr = (req_addr_i == CSR_MCYCLE) || (req_addr_i == CSR_MINSTRET) ||
               ((req_addr_i >= CSR_MHPM_BASE) && (req_addr_i < CSR_MHPM_BASE + 12'(NUM_HPM)));
    hit_uctr = (req_addr_i == CSR_CYCLE) || (req_addr_i == CSR_INSTRET) ||
               ((req_addr_i >= CSR_HPM_BASE) && (req_addr_i < CSR_HPM_BASE + 12'(NUM_HPM)));
    hit_inh  = req_addr_i == CSR_MCOUNTINHIBIT;
    illegal  = !(hit_scr || hit_mctr || hit_uctr || hit_inh) ||
               (hit_uctr && (op != CSR_OP_READ));
    wr       = req_valid_i && !illegal && (op != CSR_OP_READ);

    // Both counter pages share the low-byte layout: 0 cycle, 2 instret, 3+i hpm.
    ctr_num  = (req_addr_i[7:0] == 8'd0) ? 8'd0 : req_addr_i[7:0] - 8'd1;
    cidx     = CIDX_W'(ctr_num);
    sidx     = SIDX_W'(req_addr_i);

    old_val  = '0;
    if (hit_scr)                    old_val = scratch_q[sidx];
    else if (hit_mctr || hit_uctr)  old_val = ctr_value[cidx];
    else if (hit_inh)               old_val = inh_rd;

    new_val  = XLEN'(csr_apply_op(op, CSR_XLEN_MAX'(old_val), CSR_XLEN_MAX'(req_wdata_i)));

    for (int unsigned k = 0; k < NCNT; k++) begin
      ctr_we[k] = wr && hit_mctr && (cidx == CIDX_W'(k));
    end

    inh_d = inh_q;
    if (wr && hit_inh) begin
      inh_d[0] = new_val[0];
      inh_d[1] = new_val[2];
      for (int unsigned i = 0; i < NUM_HPM; i++) begin
        inh_d[2+i] = new_val[3+i];
      end
    end

    rsp_valid_d   = req_valid_i;
    rsp_illegal_d = req_valid_i && illegal;
    rsp_rdata_d   = (req_valid_i && !illegal) ? old_val : '0;
  end

  always_comb begin
    ctr_inc[0] = RETIRE_W'(1);
    ctr_inc[1] = instret_inc_i;
    for (int unsigned i = 0; i < NUM_HPM; i++) begin
      ctr_inc[2+i] = RETIRE_W'(hpm_event_i[i]);
    end
  end

  for (genvar k = 0; k < NCNT; k++) begin : g_ctr
    csr_counter #(
      .XLEN  (XLEN),
      .INC_W (RETIRE_W)
    ) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (ctr_inc[k]),
      .inhibit_i (inh_q[k]),
      .we_i      (ctr_we[k]),
      .wdata_i   (new_val),
      .value_o   (ctr_value[k]),
      .ovf_o     (ctr_ovf[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SCRATCH_DEPTH; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (wr && hit_scr) begin
      scratch_q[sidx] <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      inh_q         <= inh_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign ovf_o         = ctr_ovf;

endmodule

// File: tb/tb_csr_counter_file.sv
// Randomised bench for csr_counter_file against an array-based CSR model.
module tb_csr_counter_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [1:0]  req_op_i = '0;
  logic [11:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        rsp_illegal_o;
  logic [1:0]  instret_inc_i = '0;
  logic [3:0]  hpm_event_i = '0;
  logic [5:0]  ovf_o;

  always #5 clk = ~clk;

  csr_counter_file #(
    .XLEN          (64),
    .NUM_HPM       (4),
    .SCRATCH_DEPTH (32),
    .RETIRE_W      (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_illegal_o (rsp_illegal_o),
    .instret_inc_i (instret_inc_i),
    .hpm_event_i   (hpm_event_i),
    .ovf_o         (ovf_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model state: counters indexed 0 cycle, 1 instret, 2..5 hpm0..3.
  logic [63:0] m_scr [32];
  logic [63:0] m_ctr [6];
  logic [63:0] m_inh;
  localparam logic [63:0] INH_MASK = 64'h7D;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_scr[i] = '0;
    for (int i = 0; i < 6; i++) m_ctr[i] = '0;
    m_inh = '0;
  endtask

  // kind: 0 unmapped, 1 scratch, 2 machine counter, 3 user alias, 4 mcountinhibit
  task automatic decode(input logic [11:0] a, output int kind, output int idx);
    int n;
    kind = 0;
    idx  = 0;
    n    = int'(a[7:0]);
    if (a < 12'd32) begin
      kind = 1;
      idx  = int'(a);
    end else if (a == 12'h320) begin
      kind = 4;
    end else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && (n == 0 || (n >= 2 && n <= 6))) begin
      kind = (a[11:8] == 4'hB) ? 2 : 3;
      idx  = (n == 0) ? 0 : n - 1;
    end
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [11:0] a,
                      input logic [63:0] wd, input logic [1:0] ri, input logic [3:0] ev);
    int          kind, idx, ibit;
    bit          legal, wr;
    logic [63:0] old, nv, inc, e_rdata;
    logic [64:0] s;
    logic [5:0]  e_ovf;
    req_valid_i   = v;
    req_op_i      = op;
    req_addr_i    = a;
    req_wdata_i   = wd;
    instret_inc_i = ri;
    hpm_event_i   = ev;

    decode(a, kind, idx);
    legal = (kind != 0) && !(kind == 3 && op != 2'd0);
    old   = (kind == 1) ? m_scr[idx] : (kind == 2 || kind == 3) ? m_ctr[idx] :
            (kind == 4) ? m_inh : 64'd0;
    case (op)
      2'd1:    nv = wd;
      2'd2:    nv = old | wd;
      2'd3:    nv = old & ~wd;
      default: nv = old;
    endcase
    wr      = v && legal && (op != 2'd0);
    e_rdata = legal ? old : 64'd0;

    for (int k = 0; k < 6; k++) begin
      inc  = (k == 0) ? 64'd1 : (k == 1) ? 64'(ri) : 64'(ev[k-2]);
      ibit = (k == 0) ? 0 : k + 1;
      e_ovf[k] = 1'b0;
      if (wr && kind == 2 && idx == k) begin
        m_ctr[k] = nv;
      end else if (!m_inh[ibit]) begin
        s        = {1'b0, m_ctr[k]} + 65'(inc);
        m_ctr[k] = s[63:0];
        e_ovf[k] = s[64];
      end
    end
    if (wr && kind == 1) m_scr[idx] = nv;
    if (wr && kind == 4) m_inh = nv & INH_MASK;

    @(posedge clk);
    #1;
    check_eq("rsp_valid", 64'(rsp_valid_o), 64'(v));
    if (v) begin
      check_eq("rsp_illegal", 64'(rsp_illegal_o), 64'(!legal));
      check_eq("rsp_rdata", rsp_rdata_o, e_rdata);
    end
    check_eq("ovf", 64'(ovf_o), 64'(e_ovf));
  endtask

  task automatic idle(input logic [1:0] ri, input logic [3:0] ev);
    step(1'b0, 2'd0, 12'h000, 64'd0, ri, ev);
  endtask

  initial begin
    logic [11:0] a;
    logic [1:0]  op;
    logic [63:0] wd;
    int          r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_rdata", rsp_rdata_o, 64'd0);
    check_eq("rst_illegal", 64'(rsp_illegal_o), 64'd0);
    check_eq("rst_ovf", 64'(ovf_o), 64'd0);
    rst_n = 1'b1;

    repeat (10) idle(2'd0, 4'd0);
    step(1'b1, 2'd0, 12'hC00, 64'd0, 2'd0, 4'd0);
    check_eq("cycle_after_10", rsp_rdata_o, 64'd10);
    check_eq("cycle_legal", 64'(rsp_illegal_o), 64'd0);

    step(1'b1, 2'd1, 12'h005, 64'hF0, 2'd0, 4'd0);
    check_eq("scr_wr", rsp_rdata_o, 64'h0);
    step(1'b1, 2'd2, 12'h005, 64'h0F, 2'd0, 4'd0);
    check_eq("scr_set", rsp_rdata_o, 64'hF0);
    step(1'b1, 2'd3, 12'h005, 64'h30, 2'd0, 4'd0);
    check_eq("scr_clr", rsp_rdata_o, 64'hFF);
    step(1'b1, 2'd0, 12'h005, 64'h0, 2'd0, 4'd0);
    check_eq("scr_rd", rsp_rdata_o, 64'hCF);

    step(1'b1, 2'd1, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 4'd0);
    idle(2'd3, 4'd0);
    check_eq("instret_ovf_hi", 64'(ovf_o[1]), 64'd1);
    idle(2'd0, 4'd0);
    check_eq("instret_ovf_lo", 64'(ovf_o[1]), 64'd0);
    step(1'b1, 2'd0, 12'hB02, 64'd0, 2'd0, 4'd0);
    check_eq("instret_wrapped", rsp_rdata_o, 64'd1);

    step(1'b1, 2'd1, 12'h320, 64'h4, 2'd0, 4'd0);
    repeat (5) idle(2'd2, 4'd0);
    step(1'b1, 2'd0, 12'hB02, 64'd0, 2'd0, 4'd0);
    check_eq("instret_inhibited", rsp_rdata_o, 64'd1);
    step(1'b1, 2'd0, 12'h320, 64'd0, 2'd0, 4'd0);
    check_eq("inhibit_rd", rsp_rdata_o, 64'h4);
    step(1'b1, 2'd0, 12'hC00, 64'd0, 2'd0, 4'd0);
    step(1'b1, 2'd1, 12'h320, 64'd0, 2'd0, 4'd0);

    step(1'b1, 2'd1, 12'hC02, 64'd5, 2'd0, 4'd0);
    check_eq("ro_write_illegal", 64'(rsp_illegal_o), 64'd1);
    check_eq("ro_write_rdata", rsp_rdata_o, 64'd0);
    step(1'b1, 2'd0, 12'hB02, 64'd0, 2'd0, 4'd0);
    check_eq("instret_kept", rsp_rdata_o, 64'd1);
    step(1'b1, 2'd2, 12'hC00, 64'd0, 2'd0, 4'd0);
    check_eq("ro_set0_illegal", 64'(rsp_illegal_o), 64'd1);
    step(1'b1, 2'd0, 12'hB01, 64'd0, 2'd0, 4'd0);
    check_eq("b01_illegal", 64'(rsp_illegal_o), 64'd1);
    step(1'b1, 2'd0, 12'hB07, 64'd0, 2'd0, 4'd0);
    check_eq("b07_illegal", 64'(rsp_illegal_o), 64'd1);

    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 12'(i), 64'd0, 2'd0, 4'b1010);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 12'hB03 + 12'(i), 64'd0, 2'd0, 4'b1010);

    // Reset asserted with a response on the outputs and a request pending.
    step(1'b1, 2'd0, 12'hC00, 64'd0, 2'd0, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("midrst_rdata", rsp_rdata_o, 64'd0);
    check_eq("midrst_illegal", 64'(rsp_illegal_o), 64'd0);
    check_eq("midrst_ovf", 64'(ovf_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid_i = 1'b0;
    idle(2'd0, 4'd0);
    check_eq("post_rst_no_rsp", 64'(rsp_valid_o), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      r  = int'($urandom_range(0, 9));
      op = 2'($urandom_range(0, 3));
      wd = {$urandom(), $urandom()};
      case (r)
        0, 1, 2, 3: a = 12'($urandom_range(0, 31));
        4:          a = 12'hB00 + 12'($urandom_range(0, 7));
        5:          a = 12'hC00 + 12'($urandom_range(0, 7));
        6:          a = 12'h320;
        7:          a = 12'($urandom());
        8:          a = ($urandom_range(0, 1) != 0) ? 12'hB01 : 12'hC01;
        default: begin
          op = 2'd1;
          a  = 12'hB00 + 12'($urandom_range(2, 6));
          if (a == 12'hB01) a = 12'hB00;
          wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        end
      endcase
      if (a == 12'h320 && $urandom_range(0, 1) != 0) wd = wd & 64'h1;
      step(($urandom_range(0, 3) != 0), op, a, wd, 2'($urandom_range(0, 3)), 4'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
